data_mem_pipe: RTL and testbench
================================

DATA_MEM_PIPE -- requirements
Module: data_mem_pipe

Interface
REQ-001 Parameter ADDR_W, default 64, byte-address width.
REQ-002 Parameter DATA_W, default 64, data port width in bits; multiple of 8.
REQ-003 Parameter DEPTH, default 1024, storage size in bytes; power of two.
REQ-004 Parameter RD_LAT, default 1, cycles from acceptance to response; legal range 1..4.
REQ-005 Ports SHALL be:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset; asynchronous, active-low.
- i_req  in  1  request strobe.
- i_we  in  1  1 = store, 0 = load.
- i_size  in  2  access size: 0 = byte, 1 = half, 2 = word, 3 = double.
- i_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- i_addr  in  ADDR_W  byte address.
- i_wdata  in  DATA_W  store data, LSB-aligned.
- o_ready  out  1  request can be accepted this cycle.
- o_valid  out  1  one-cycle response pulse.
- o_err  out  1  response carries an error; qualified by o_valid.
- o_rdata  out  DATA_W  load result; 0 for stores and errors.

Function
REQ-006 A request SHALL be accepted on a rising edge where i_req && o_ready; inputs are ignored otherwise.
REQ-007 The FSM SHALL have states IDLE, WAIT and RESP:
- IDLE --accept--> WAIT when RD_LAT>1, else RESP.
- WAIT stays for RD_LAT-1 cycles on a down-counter, then goes to RESP.
- RESP --accept--> WAIT or RESP as from IDLE; RESP with no accept goes to IDLE.
REQ-008 o_ready SHALL be 1 in IDLE and RESP and 0 in WAIT; at most one request is outstanding.
REQ-009 o_valid SHALL be 1 exactly in RESP, i.e. RD_LAT cycles after the accepting edge.
REQ-010 Stores SHALL write bytes addr .. addr+2^size-1 little-endian from i_wdata[8*2^size-1:0] at the accepting edge.
- Each store also produces a response with o_rdata = 0.
REQ-011 Loads SHALL sample memory at the accepting edge, assemble the bytes little-endian, then zero- or sign-extend to DATA_W.
- The result is held in a register until RESP.
REQ-012 A load accepted in the RESP cycle of a store to the same bytes SHALL return the stored data.
REQ-013 An access with addr+2^size > DEPTH SHALL set o_err=1 in its response, write nothing and return o_rdata=0.
REQ-014 i_size encoding 3 with DATA_W<64 SHALL be treated as an error per REQ-013.
REQ-015 o_rdata and o_err SHALL be 0 whenever o_valid=0.

Reset
REQ-016 Asserting i_rst_n low SHALL immediately force: state IDLE, o_valid=0, o_err=0, o_rdata=0, wait counter 0, all DEPTH bytes 0.
REQ-017 Reset during WAIT or RESP SHALL abort the pending request with no response and no partial store; o_ready=1 on the first cycle after release.

Configuration
REQ-018 Macro DATA_MEM_ALIGN_CHECK_EN SHALL control misaligned accesses (addr mod 2^size != 0):
- Defined: a misaligned access is an error per REQ-013 (o_err=1, no write, o_rdata=0).
- Undefined: a misaligned access is performed byte-wise as normal, and o_err is raised only for range errors.

Structure
REQ-019 Shared package data_mem_pkg SHALL hold:
- Size encodings SZ_B/SZ_H/SZ_W/SZ_D.
- The FSM state enum.
- Function size_bytes(size).
REQ-020 Storage SHALL be a sub-module data_mem_bytes: DEPTH x 8 array, async reset clear, byte-enable write port, combinational DATA_W-wide little-endian read port. All other logic lives in the top level.

Verification
REQ-021 Store double 0x1122334455667788 @0x10, then load double @0x10 -> o_valid at RD_LAT, o_rdata=0x1122334455667788, o_err=0.
REQ-022 Store byte 0x80 @0x20, then load byte signed -> 0xFFFFFFFFFFFFFF80; same load unsigned -> 0x80.
REQ-023 RD_LAT=3, back-to-back requests:
- o_ready low for 2 cycles after each accept.
- One response per request, in order.
- A store-then-load pair to the same address returns the new data.
REQ-024 Load word @DEPTH-2 -> o_err=1, o_rdata=0; no memory change verified by readback.
REQ-025 Store half @0x31:
- With DATA_MEM_ALIGN_CHECK_EN: o_err=1 and bytes 0x31..0x32 unchanged.
- Without it: o_err=0 and readback matches.
REQ-026 Reset asserted in WAIT after a store accept (RD_LAT=2) -> no o_valid, memory all zero, o_ready=1 after release.

Source files
------------

// File: rtl/data_mem_pkg.sv
// Shared definitions for the pipelined byte-addressable data memory:
// access-size encodings, response FSM states and a size helper.
package data_mem_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    function automatic int unsigned size_bytes(input logic [1:0] size);
        return 32'd1 << size;
    endfunction

endpackage

// File: rtl/data_mem_bytes.sv
// Byte storage: DEPTH x 8 array cleared by asynchronous reset, byte-enable
// write port and combinational little-endian DATA_W-wide read port.
module data_mem_bytes #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 1024,
    localparam int AW    = $clog2(DEPTH),
    localparam int NB    = DATA_W / 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [AW-1:0]     i_addr,
    input  logic [NB-1:0]     i_be,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [7:0] mem_q [DEPTH];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'd0;
            end
        end else begin
            for (int b = 0; b < NB; b++) begin
                if (i_be[b]) begin
                    mem_q[i_addr + AW'(b)] <= i_wdata[8*b +: 8];
                end
            end
        end
    end

    // Indices past the top wrap; those lanes are masked by the caller.
    for (genvar gi = 0; gi < NB; gi++) begin : g_rd
        assign o_rdata[8*gi +: 8] = mem_q[i_addr + AW'(gi)];
    end

endmodule

// File: rtl/data_mem_pipe.sv
// Pipelined load/store data memory with RD_LAT-cycle response latency.
// Define DATA_MEM_ALIGN_CHECK_EN to flag misaligned accesses as errors.
module data_mem_pipe
    import data_mem_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int DEPTH  = 1024,
    parameter int RD_LAT = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req,
    input  logic              i_we,
    input  logic [1:0]        i_size,
    input  logic              i_unsigned,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic              o_ready,
    output logic              o_valid,
    output logic              o_err,
    output logic [DATA_W-1:0] o_rdata
);

    localparam int AW = $clog2(DEPTH);
    localparam int NB = DATA_W / 8;
    localparam int IW = $clog2(DATA_W);
    localparam logic [1:0] CNT_INIT = 2'((RD_LAT > 1) ? RD_LAT - 2 : 0);

    state_e              state_q, state_d;
    logic [1:0]          cnt_q, cnt_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;

    logic                accept;
    int unsigned         nbytes;
    logic [ADDR_W:0]     end_addr;
    logic                range_err, width_err, align_err, req_err;
    logic [NB-1:0]       wr_be;
    logic [DATA_W-1:0]   mem_rdata, load_val;
    logic [IW-1:0]       msb_idx;
    logic                sign_bit;

    assign o_ready   = (state_q != ST_WAIT);
    assign accept    = i_req && o_ready;
    assign nbytes    = size_bytes(i_size);
    assign end_addr  = {1'b0, i_addr} + (ADDR_W+1)'(nbytes);
    assign range_err = end_addr > (ADDR_W+1)'(DEPTH);
    assign width_err = nbytes > NB;
`ifdef DATA_MEM_ALIGN_CHECK_EN
    assign align_err = (i_addr[2:0] & 3'(nbytes - 1)) != 3'd0;
`else
    assign align_err = 1'b0;
`endif
    assign req_err   = range_err || width_err || align_err;

    for (genvar gi = 0; gi < NB; gi++) begin : g_be
        assign wr_be[gi] = accept && i_we && !req_err && (gi < nbytes);
    end

    data_mem_bytes #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_bytes (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_addr  (i_addr[AW-1:0]),
        .i_be    (wr_be),
        .i_wdata (i_wdata),
        .o_rdata (mem_rdata)
    );

    // Keep the low nbytes lanes, fill the rest with zero or the sign bit.
    always_comb begin
        msb_idx  = IW'(8 * nbytes - 1);
        sign_bit = !i_unsigned && mem_rdata[msb_idx];
        load_val = '0;
        for (int b = 0; b < NB; b++) begin
            load_val[8*b +: 8] = (b < nbytes) ? mem_rdata[8*b +: 8] : {8{sign_bit}};
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE, ST_RESP: begin
                if (accept) begin
                    state_d = (RD_LAT > 1) ? ST_WAIT : ST_RESP;
                    cnt_d   = CNT_INIT;
                    rdata_d = (i_we || req_err) ? '0 : load_val;
                    err_d   = req_err;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 2'd0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 2'd0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign o_valid = (state_q == ST_RESP);
    assign o_err   = o_valid && err_q;
    assign o_rdata = o_valid ? rdata_q : '0;

endmodule

// File: tb/tb_data_mem_pipe.sv
// Directed table-driven bench for data_mem_pipe (RD_LAT=3), plus hand-written
// back-to-back and reset-abort sequences.
module tb_data_mem_pipe;

    localparam int RD_LAT = 3;
    localparam int DEPTH  = 1024;
`ifdef DATA_MEM_ALIGN_CHECK_EN
    localparam bit ALIGN_CHK = 1'b1;
`else
    localparam bit ALIGN_CHK = 1'b0;
`endif

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_req;
    logic        i_we;
    logic [1:0]  i_size;
    logic        i_unsigned;
    logic [63:0] i_addr;
    logic [63:0] i_wdata;
    logic        o_ready, o_valid, o_err;
    logic [63:0] o_rdata;

    int checks   = 0;
    int failures = 0;

    always #5 i_clk = ~i_clk;

    data_mem_pipe #(
        .ADDR_W (64),
        .DATA_W (64),
        .DEPTH  (DEPTH),
        .RD_LAT (RD_LAT)
    ) u_dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_req      (i_req),
        .i_we       (i_we),
        .i_size     (i_size),
        .i_unsigned (i_unsigned),
        .i_addr     (i_addr),
        .i_wdata    (i_wdata),
        .o_ready    (o_ready),
        .o_valid    (o_valid),
        .o_err      (o_err),
        .o_rdata    (o_rdata)
    );

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic we, input logic [1:0] size, input logic uns,
                                input logic [63:0] addr, input logic [63:0] wdata,
                                input logic [63:0] exp_rdata, input logic exp_err);
        vec_t v;
        v.we = we; v.size = size; v.uns = uns; v.addr = addr;
        v.wdata = wdata; v.exp_rdata = exp_rdata; v.exp_err = exp_err;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [1:0] size, input logic uns,
                         input logic [63:0] addr, input logic [63:0] wdata);
        i_req = 1'b1; i_we = we; i_size = size; i_unsigned = uns;
        i_addr = addr; i_wdata = wdata;
    endtask

    // One isolated transaction; checks latency, quiet outputs while waiting,
    // response payload and the single-cycle pulse.
    task automatic run_txn(input string name, input logic we, input logic [1:0] size,
                           input logic uns, input logic [63:0] addr, input logic [63:0] wdata,
                           input logic [63:0] exp_rdata, input logic exp_err);
        int  lat;
        bit  got;
        @(negedge i_clk);
        drive(we, size, uns, addr, wdata);
        check({name, ".ready"}, 64'(o_ready), 64'd1);
        @(negedge i_clk);
        i_req = 1'b0;
        lat = 1;
        got = 1'b0;
        while (!got && lat <= RD_LAT + 4) begin
            if (o_valid) begin
                got = 1'b1;
            end else begin
                check({name, ".idle_out"}, {o_err, o_rdata[62:0]}, 64'd0);
                @(negedge i_clk);
                lat++;
            end
        end
        check({name, ".latency"}, got ? 64'(lat) : 64'd0, 64'(RD_LAT));
        if (got) begin
            check({name, ".rdata"}, o_rdata, exp_rdata);
            check({name, ".err"}, 64'(o_err), 64'(exp_err));
            $display("txn %s we=%0b size=%0d addr=%h rdata=%h err=%0b lat=%0d",
                     name, we, size, addr, o_rdata, o_err, lat);
            @(negedge i_clk);
            check({name, ".pulse"}, 64'(o_valid), 64'd0);
        end
    endtask

    initial begin
        i_rst_n = 1'b0;
        i_req = 1'b0; i_we = 1'b0; i_size = 2'd0; i_unsigned = 1'b0;
        i_addr = '0; i_wdata = '0;

        // Vector table: we, size, uns, addr, wdata, exp_rdata, exp_err
        add(1, 2'd3, 0, 64'h10, 64'h1122334455667788, 64'h0, 0);
        add(0, 2'd3, 1, 64'h10, 64'h0, 64'h1122334455667788, 0);
        add(0, 2'd3, 0, 64'h10, 64'h0, 64'h1122334455667788, 0);
        add(1, 2'd0, 0, 64'h20, 64'h80, 64'h0, 0);
        add(0, 2'd0, 0, 64'h20, 64'h0, 64'hFFFFFFFFFFFFFF80, 0);
        add(0, 2'd0, 1, 64'h20, 64'h0, 64'h80, 0);
        add(0, 2'd1, 0, 64'h10, 64'h0, 64'h7788, 0);
        add(0, 2'd2, 0, 64'h14, 64'h0, 64'h11223344, 0);
        add(1, 2'd2, 0, 64'h40, 64'hDEADBEEF, 64'h0, 0);
        add(0, 2'd2, 0, 64'h40, 64'h0, 64'hFFFFFFFFDEADBEEF, 0);
        add(0, 2'd2, 1, 64'h40, 64'h0, 64'hDEADBEEF, 0);
        add(0, 2'd1, 1, 64'h42, 64'h0, 64'hDEAD, 0);
        add(0, 2'd0, 0, 64'h43, 64'h0, 64'hFFFFFFFFFFFFFFDE, 0);
        add(1, 2'd0, 0, 64'h50, 64'hFFFFFFFFFFFFFFAB, 64'h0, 0);
        add(0, 2'd1, 1, 64'h50, 64'h0, 64'hAB, 0);
        add(0, 2'd2, 1, 64'(DEPTH-2), 64'h0, 64'h0, 1);
        add(0, 2'd1, 1, 64'(DEPTH-2), 64'h0, 64'h0, 0);
        add(1, 2'd3, 0, 64'(DEPTH-4), 64'hA5A5A5A5A5A5A5A5, 64'h0, 1);
        add(0, 2'd2, 1, 64'(DEPTH-4), 64'h0, 64'h0, 0);
        add(1, 2'd3, 0, 64'(DEPTH-8), 64'h0102030405060708, 64'h0, 0);
        add(0, 2'd0, 1, 64'(DEPTH-1), 64'h0, 64'h01, 0);
        add(0, 2'd1, 1, 64'(DEPTH-2), 64'h0, 64'h0102, 0);
        add(1, 2'd1, 0, 64'h31, 64'hBEEF, 64'h0, ALIGN_CHK);
        add(0, 2'd0, 1, 64'h31, 64'h0, ALIGN_CHK ? 64'h0 : 64'hEF, 0);
        add(0, 2'd0, 1, 64'h32, 64'h0, ALIGN_CHK ? 64'h0 : 64'hBE, 0);
        add(0, 2'd1, 1, 64'h31, 64'h0, ALIGN_CHK ? 64'h0 : 64'hBEEF, ALIGN_CHK);
        add(0, 2'd0, 1, 64'h30, 64'h0, 64'h0, 0);
        add(0, 2'd0, 1, 64'h33, 64'h0, 64'h0, 0);

        // Reset state
        #2;
        check("rst.valid", 64'(o_valid), 64'd0);
        check("rst.err", 64'(o_err), 64'd0);
        check("rst.rdata", o_rdata, 64'd0);
        check("rst.ready", 64'(o_ready), 64'd1);
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            run_txn($sformatf("vec%0d", i), vecs[i].we, vecs[i].size, vecs[i].uns,
                    vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_err);
        end

        // Back-to-back store then load; the load is presented during WAIT
        // and must only be taken in the store's RESP cycle.
        @(negedge i_clk);
        drive(1, 2'd2, 0, 64'h60, 64'hCAFEF00D);
        check("b2b.st_ready", 64'(o_ready), 64'd1);
        @(negedge i_clk);
        drive(0, 2'd2, 1, 64'h60, 64'h0);
        for (int k = 1; k < RD_LAT; k++) begin
            check($sformatf("b2b.st_wait_ready%0d", k), 64'(o_ready), 64'd0);
            check($sformatf("b2b.st_wait_valid%0d", k), 64'(o_valid), 64'd0);
            @(negedge i_clk);
        end
        check("b2b.st_valid", 64'(o_valid), 64'd1);
        check("b2b.st_rdata", o_rdata, 64'd0);
        check("b2b.st_err", 64'(o_err), 64'd0);
        check("b2b.st_resp_ready", 64'(o_ready), 64'd1);
        $display("txn b2b.store addr=0000000000000060 valid=%0b rdata=%h", o_valid, o_rdata);
        @(negedge i_clk);
        i_req = 1'b0;
        for (int k = 1; k < RD_LAT; k++) begin
            check($sformatf("b2b.ld_wait_ready%0d", k), 64'(o_ready), 64'd0);
            check($sformatf("b2b.ld_wait_valid%0d", k), 64'(o_valid), 64'd0);
            @(negedge i_clk);
        end
        check("b2b.ld_valid", 64'(o_valid), 64'd1);
        check("b2b.ld_rdata", o_rdata, 64'hCAFEF00D);
        check("b2b.ld_err", 64'(o_err), 64'd0);
        $display("txn b2b.load addr=0000000000000060 valid=%0b rdata=%h", o_valid, o_rdata);
        @(negedge i_clk);
        check("b2b.ld_pulse", 64'(o_valid), 64'd0);

        // Reset while a store waits: no response, no write, memory cleared.
        @(negedge i_clk);
        drive(1, 2'd3, 0, 64'h70, 64'h0123456789ABCDEF);
        check("rstw.ready", 64'(o_ready), 64'd1);
        @(negedge i_clk);
        i_req = 1'b0;
        check("rstw.in_wait", 64'(o_ready), 64'd0);
        i_rst_n = 1'b0;
        #1;
        check("rstw.async_ready", 64'(o_ready), 64'd1);
        check("rstw.async_valid", 64'(o_valid), 64'd0);
        for (int k = 0; k < RD_LAT + 1; k++) begin
            @(negedge i_clk);
            check($sformatf("rstw.hold_valid%0d", k), 64'(o_valid), 64'd0);
        end
        i_rst_n = 1'b1;
        @(negedge i_clk);
        check("rstw.rel_ready", 64'(o_ready), 64'd1);
        check("rstw.rel_valid", 64'(o_valid), 64'd0);
        $display("txn rstw.release ready=%0b valid=%0b", o_ready, o_valid);
        run_txn("rstw.ld70", 0, 2'd3, 1, 64'h70, 64'h0, 64'h0, 0);
        run_txn("rstw.ld10", 0, 2'd3, 1, 64'h10, 64'h0, 64'h0, 0);
        run_txn("rstw.ld40", 0, 2'd2, 1, 64'h40, 64'h0, 64'h0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
